csr_write_unit: RTL and testbench

- Machine-mode CSR writer and trap sequencer.
- Sits beside the WB stage, opposite the counter/read path.
- Executes the read-modify-write CSR instructions (CSRRW/CSRRS/CSRRC and their immediate forms) on mstatus, mie, mtvec, mepc, mcause and mip.
- Detects enabled interrupts and MRET, and drives a one-cycle PC redirect to the fetch stage.

---
 rtl/csr_pkg.sv | 74 +++++++
 rtl/csr_irq_arbiter.sv | 44 ++++
 rtl/csr_write_unit.sv | 206 ++++++++++++++++++++
 tb/tb_csr_write_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// ============================================================================
// Module  : csr_pkg
// Purpose : Shared definitions for the machine-mode CSR write / trap unit.
//           Holds CSR addresses, writable-bit masks, interrupt cause codes,
//           the CSR op encoding, the sequencer state type and the
//           read-modify-write helper.
// Config  : CSR_VECTORED_EN -- when defined, mtvec[0] (MODE) is writable.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package csr_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // Bit positions inside mstatus / mie / mip
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int IRQ_MTI_BIT      = 7;
  localparam int IRQ_MEI_BIT      = 11;

  // Writable-bit masks, applied after the read-modify-write operation
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_MPP   = 32'h0000_1800;  // MPP reads as M-mode
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0880;
`ifdef CSR_VECTORED_EN
  localparam logic [31:0] MTVEC_WMASK   = 32'hFFFF_FFFD;
`else
  localparam logic [31:0] MTVEC_WMASK   = 32'hFFFF_FFFC;
`endif
  localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;
  localparam logic [31:0] MCAUSE_WMASK  = 32'hFFFF_FFFF;

  // Interrupt cause codes (low bits of mcause)
  localparam logic [3:0] IRQ_M_TIMER = 4'd7;
  localparam logic [3:0] IRQ_M_EXT   = 4'd11;

  // funct3[1:0] operation; funct3[2] only selects the immediate source
  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_W    = 2'b01,
    CSR_OP_S    = 2'b10,
    CSR_OP_C    = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_RET  = 2'd2
  } csr_state_e;

  // Unmasked read-modify-write result; a non-CSR op leaves the value as is
  function automatic logic [31:0] csr_rmw(input csr_op_e op,
                                          input logic [31:0] old_val,
                                          input logic [31:0] src);
    logic [31:0] res;
    case (op)
      CSR_OP_W: res = src;
      CSR_OP_S: res = old_val | src;
      CSR_OP_C: res = old_val & ~src;
      default:  res = old_val;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/csr_irq_arbiter.sv
// ============================================================================
// Module  : csr_irq_arbiter
// Purpose : Combinational interrupt pending / priority / cause encoder.
// Ports   : mstatus_mie_i  global machine interrupt enable
//           mie_i          mie register contents
//           ext_irq_i      external interrupt level
//           timer_irq_i    timer interrupt level
//           commit_i       an instruction retires this cycle
//           mip_o          mip read value
//           take_o         take an interrupt at this commit
//           cause_o        cause code of the highest-priority pending irq
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_irq_arbiter
  import csr_pkg::*;
(
  input  logic        mstatus_mie_i,
  input  logic [31:0] mie_i,
  input  logic        ext_irq_i,
  input  logic        timer_irq_i,
  input  logic        commit_i,
  output logic [31:0] mip_o,
  output logic        take_o,
  output logic [3:0]  cause_o
);

  logic [31:0] pending;

  always_comb begin
    mip_o              = '0;
    mip_o[IRQ_MEI_BIT] = ext_irq_i;
    mip_o[IRQ_MTI_BIT] = timer_irq_i;
  end

  assign pending = mip_o & mie_i;
  assign take_o  = mstatus_mie_i & (|pending) & commit_i;
  // External interrupts outrank the timer
  assign cause_o = pending[IRQ_MEI_BIT] ? IRQ_M_EXT : IRQ_M_TIMER;

endmodule

`default_nettype wire

// File: rtl/csr_write_unit.sv
// ============================================================================
// Module  : csr_write_unit
// Purpose : Machine-mode CSR writer and trap sequencer beside the WB stage.
//           Executes CSRRW/S/C(I) on mstatus, mie, mtvec, mepc, mcause, mip,
//           takes enabled interrupts at commit, handles MRET and drives a
//           one-cycle fetch redirect.
// Config  : CSR_VECTORED_EN -- mtvec MODE bit writable; MODE=1 vectors traps
//           to base + 4*cause.
// Ports   : clk, rst (async, active-low)
//           wb_csr_valid/wb_funct3/wb_csr_addr/wb_rs1_idx/wb_rs1_data  CSR op
//           wb_commit, wb_next_pc, wb_mret                         retire info
//           ext_irq, timer_irq                                     irq levels
//           csr_rdata                                   old CSR value (comb)
//           redirect_valid, redirect_pc                       fetch redirect
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_write_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_csr_valid,
  input  logic [2:0]  wb_funct3,
  input  logic [11:0] wb_csr_addr,
  input  logic [4:0]  wb_rs1_idx,
  input  logic [31:0] wb_rs1_data,
  input  logic        wb_commit,
  input  logic [31:0] wb_next_pc,
  input  logic        wb_mret,
  input  logic        ext_irq,
  input  logic        timer_irq,
  output logic [31:0] csr_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  csr_state_e  state_q, state_d;
  logic        mst_mie_q, mst_mie_d;
  logic        mst_mpie_q, mst_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] save_pc_q, save_pc_d;
  logic [3:0]  cause_q, cause_d;

  logic [31:0] mstatus_rd, mip_rd, old_val, src, new_val, trap_pc;
  logic [3:0]  irq_cause;
  logic        take, wr_en;
  csr_op_e     op;

  csr_irq_arbiter u_arb (
    .mstatus_mie_i (mst_mie_q),
    .mie_i         (mie_q),
    .ext_irq_i     (ext_irq),
    .timer_irq_i   (timer_irq),
    .commit_i      (wb_commit),
    .mip_o         (mip_rd),
    .take_o        (take),
    .cause_o       (irq_cause)
  );

  always_comb begin
    mstatus_rd                   = MSTATUS_MPP;
    mstatus_rd[MSTATUS_MIE_BIT]  = mst_mie_q;
    mstatus_rd[MSTATUS_MPIE_BIT] = mst_mpie_q;
  end

  always_comb begin
    case (wb_csr_addr)
      CSR_MSTATUS: old_val = mstatus_rd;
      CSR_MIE:     old_val = mie_q;
      CSR_MTVEC:   old_val = mtvec_q;
      CSR_MEPC:    old_val = mepc_q;
      CSR_MCAUSE:  old_val = mcause_q;
      CSR_MIP:     old_val = mip_rd;
      default:     old_val = '0;
    endcase
  end

  // Gated by rst so the read port is quiet while reset is held
  assign csr_rdata = (wb_csr_valid && rst) ? old_val : '0;

  assign op      = csr_op_e'(wb_funct3[1:0]);
  assign src     = wb_funct3[2] ? {27'b0, wb_rs1_idx} : wb_rs1_data;
  assign new_val = csr_rmw(op, old_val, src);
  // Set/clear with rs1/zimm = 0 is a pure read
  assign wr_en   = wb_csr_valid && (state_q == ST_IDLE) &&
                   !((op != CSR_OP_W) && (wb_rs1_idx == 5'd0));

  // Architectural register next-state; trap/return updates are applied
  // after the CSR write so they take precedence on shared fields.
  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    save_pc_d  = save_pc_q;
    cause_d    = cause_q;

    if (wr_en) begin
      case (wb_csr_addr)
        CSR_MSTATUS: begin
          mst_mie_d  = new_val[MSTATUS_MIE_BIT];
          mst_mpie_d = new_val[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:    mie_d    = new_val & MIE_WMASK;
        CSR_MTVEC:  mtvec_d  = new_val & MTVEC_WMASK;
        CSR_MEPC:   mepc_d   = new_val & MEPC_WMASK;
        CSR_MCAUSE: mcause_d = new_val & MCAUSE_WMASK;
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (take) begin
          save_pc_d = wb_next_pc;
          cause_d   = irq_cause;
        end
      end
      ST_TRAP: begin
        mepc_d     = save_pc_q & MEPC_WMASK;
        mcause_d   = {1'b1, 27'b0, cause_q};
        mst_mpie_d = mst_mie_q;
        mst_mie_d  = 1'b0;
      end
      ST_RET: begin
        mst_mie_d  = mst_mpie_q;
        mst_mpie_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= RESET_MTVEC & MTVEC_WMASK;
      mepc_q     <= '0;
      mcause_q   <= '0;
      save_pc_q  <= '0;
      cause_q    <= '0;
    end else begin
      state_q    <= state_d;
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      save_pc_q  <= save_pc_d;
      cause_q    <= cause_d;
    end
  end

  // Next-state logic: an interrupt beats a simultaneous MRET
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (take)         state_d = ST_TRAP;
        else if (wb_mret) state_d = ST_RET;
        else              state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef CSR_VECTORED_EN
  assign trap_pc = mtvec_q[0] ? ({mtvec_q[31:2], 2'b00} + {26'b0, cause_q, 2'b00})
                              : {mtvec_q[31:2], 2'b00};
`else
  assign trap_pc = mtvec_q & 32'hFFFF_FFFC;
`endif

  // Output logic
  always_comb begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      ST_TRAP: begin
        redirect_valid = 1'b1;
        redirect_pc    = trap_pc;
      end
      ST_RET: begin
        redirect_valid = 1'b1;
        redirect_pc    = mepc_q;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_csr_write_unit.sv
// ============================================================================
// Module  : tb_csr_write_unit
// Purpose : Self-checking bench for csr_write_unit: CSR access table,
//           directed trap / MRET / reset sequences and a randomized phase
//           compared against a behavioural model of the CSR file.
// Config  : CSR_VECTORED_EN -- expectations follow the vectored mtvec mode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_write_unit;

  localparam logic [31:0] RST_MTVEC = 32'h0000_4000;
`ifdef CSR_VECTORED_EN
  localparam logic [31:0] TV_MASK = 32'hFFFF_FFFD;
  localparam bit          VEC     = 1'b1;
`else
  localparam logic [31:0] TV_MASK = 32'hFFFF_FFFC;
  localparam bit          VEC     = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_csr_valid;
  logic [2:0]  wb_funct3;
  logic [11:0] wb_csr_addr;
  logic [4:0]  wb_rs1_idx;
  logic [31:0] wb_rs1_data;
  logic        wb_commit;
  logic [31:0] wb_next_pc;
  logic        wb_mret;
  logic        ext_irq;
  logic        timer_irq;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  csr_write_unit #(.RESET_MTVEC(RST_MTVEC)) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_csr_valid   (wb_csr_valid),
    .wb_funct3      (wb_funct3),
    .wb_csr_addr    (wb_csr_addr),
    .wb_rs1_idx     (wb_rs1_idx),
    .wb_rs1_data    (wb_rs1_data),
    .wb_commit      (wb_commit),
    .wb_next_pc     (wb_next_pc),
    .wb_mret        (wb_mret),
    .ext_irq        (ext_irq),
    .timer_irq      (timer_irq),
    .csr_rdata      (csr_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        md_mie, md_mpie;
  logic [31:0] md_mie_reg, md_mtvec, md_mepc, md_mcause;
  logic        md_busy, md_trap;      // a redirect is due this cycle
  logic [31:0] md_save;
  logic [3:0]  md_cause;

  task automatic m_reset();
    md_mie = 0; md_mpie = 0; md_mie_reg = 0;
    md_mtvec = RST_MTVEC & TV_MASK; md_mepc = 0; md_mcause = 0;
    md_busy = 0; md_trap = 0; md_save = 0; md_cause = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_1800 | (32'(md_mpie) << 7) | (32'(md_mie) << 3);
      12'h304: return md_mie_reg;
      12'h305: return md_mtvec;
      12'h341: return md_mepc;
      12'h342: return md_mcause;
      12'h344: return (32'(ext_irq) << 11) | (32'(timer_irq) << 7);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] base;
    base = md_mtvec & 32'hFFFF_FFFC;
    if (!md_trap) return md_mepc;
    if (VEC && md_mtvec[0]) return base + 32'(md_cause) * 4;
    return base;
  endfunction

  task automatic m_step();
    logic [31:0] old, s, nv;
    logic        pe, pt, tk;
    if (md_busy) begin
      if (md_trap) begin
        md_mepc   = md_save & 32'hFFFF_FFFC;
        md_mcause = 32'h8000_0000 | 32'(md_cause);
        md_mpie   = md_mie;
        md_mie    = 0;
      end else begin
        md_mie  = md_mpie;
        md_mpie = 1;
      end
      md_busy = 0;
    end else begin
      pe = ext_irq & md_mie_reg[11];
      pt = timer_irq & md_mie_reg[7];
      tk = md_mie && (pe || pt) && wb_commit;
      if (wb_csr_valid && (wb_funct3[1:0] == 2'b01 || wb_rs1_idx != 0)) begin
        old = m_read(wb_csr_addr);
        s   = wb_funct3[2] ? 32'(wb_rs1_idx) : wb_rs1_data;
        case (wb_funct3[1:0])
          2'b01:   nv = s;
          2'b10:   nv = old | s;
          2'b11:   nv = old & ~s;
          default: nv = old;
        endcase
        case (wb_csr_addr)
          12'h300: begin md_mie = nv[3]; md_mpie = nv[7]; end
          12'h304: md_mie_reg = nv & 32'h0000_0880;
          12'h305: md_mtvec   = nv & TV_MASK;
          12'h341: md_mepc    = nv & 32'hFFFF_FFFC;
          12'h342: md_mcause  = nv;
          default: ;
        endcase
      end
      if (tk) begin
        md_busy = 1; md_trap = 1; md_save = wb_next_pc;
        md_cause = pe ? 4'd11 : 4'd7;
      end else if (wb_mret) begin
        md_busy = 1; md_trap = 0;
      end
    end
  endtask

  // ---------------- drivers ----------------
  logic [31:0] last_rdata, last_rpc;
  logic        last_rv;

  task automatic idle_inputs();
    wb_csr_valid = 0; wb_funct3 = 0; wb_csr_addr = 0; wb_rs1_idx = 0;
    wb_rs1_data = 0; wb_commit = 0; wb_next_pc = 0; wb_mret = 0;
    ext_irq = 0; timer_irq = 0;
  endtask

  // Called just after a falling edge with inputs applied
  task automatic tick();
    logic [31:0] er;
    #1;
    er = (wb_csr_valid && rst) ? m_read(wb_csr_addr) : 32'h0;
    chk("rdata", csr_rdata, er);
    chk("redirect_valid", 32'(redirect_valid), 32'(md_busy));
    chk("redirect_pc", redirect_pc, md_busy ? m_target() : 32'h0);
    last_rdata = csr_rdata; last_rv = redirect_valid; last_rpc = redirect_pc;
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic csr_op(input logic [2:0] f3, input logic [11:0] a,
                        input logic [4:0] idx, input logic [31:0] d);
    wb_csr_valid = 1; wb_funct3 = f3; wb_csr_addr = a; wb_rs1_idx = idx; wb_rs1_data = d;
    tick();
    wb_csr_valid = 0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] v);
    csr_op(3'b010, a, 5'd0, 32'hFFFF_FFFF);
    v = last_rdata;
  endtask

  task automatic do_reset();
    idle_inputs();
    wb_csr_valid = 1; wb_csr_addr = 12'h300;
    rst = 0;
    #1;
    chk("rst_redirect_valid", 32'(redirect_valid), 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_rdata", csr_rdata, 32'h0);
    m_reset();
    @(posedge clk); @(negedge clk);
    rst = 1;
    idle_inputs();
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  idx;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl[12];
  logic [31:0] v;
  logic [2:0]  f3_pool[7]  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
  logic [11:0] adr_pool[8] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h123, 12'h000};

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{3'b001, 12'h305, 5'd1, 32'h8000_0103, VEC ? 32'h8000_0101 : 32'h8000_0100};
    tbl[1]  = '{3'b110, 12'h300, 5'd8, 32'h0,         32'h0000_1808};
    tbl[2]  = '{3'b011, 12'h300, 5'd0, 32'hFFFF_FFFF, 32'h0000_1808};
    tbl[3]  = '{3'b001, 12'h304, 5'd1, 32'hFFFF_FFFF, 32'h0000_0880};
    tbl[4]  = '{3'b011, 12'h304, 5'd1, 32'h0000_0080, 32'h0000_0800};
    tbl[5]  = '{3'b111, 12'h300, 5'd8, 32'h0,         32'h0000_1800};
    tbl[6]  = '{3'b001, 12'h341, 5'd1, 32'h0000_0203, 32'h0000_0200};
    tbl[7]  = '{3'b001, 12'h342, 5'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[8]  = '{3'b001, 12'h344, 5'd1, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[9]  = '{3'b001, 12'h123, 5'd1, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[10] = '{3'b010, 12'h342, 5'd2, 32'h0000_0010, 32'hDEAD_BEFF};
    tbl[11] = '{3'b001, 12'h300, 5'd1, 32'hFFFF_FFFF, 32'h0000_1888};

    idle_inputs();
    rst = 1;
    @(negedge clk);
    do_reset();
    csr_read(12'h305, v); chk("reset_mtvec", v, RST_MTVEC & TV_MASK);
    csr_read(12'h300, v); chk("reset_mstatus", v, 32'h0000_1800);

    // CSR access table
    for (int i = 0; i < 12; i++) begin
      csr_op(tbl[i].f3, tbl[i].addr, tbl[i].idx, tbl[i].data);
      csr_read(tbl[i].addr, v);
      chk($sformatf("tbl[%0d]", i), v, tbl[i].exp);
    end

    // Timer trap, with an mtvec write in the same commit cycle
    do_reset();
    csr_op(3'b001, 12'h300, 5'd1, 32'h8);
    csr_op(3'b001, 12'h304, 5'd1, 32'h80);
    wb_csr_valid = 1; wb_funct3 = 3'b001; wb_csr_addr = 12'h305; wb_rs1_idx = 5'd1;
    wb_rs1_data = 32'h1000; timer_irq = 1; wb_commit = 1; wb_next_pc = 32'h100;
    tick();
    chk("trap_latency_rv", 32'(last_rv), 32'h0);
    idle_inputs();
    tick();
    chk("trap_rv", 32'(last_rv), 32'h1);
    chk("trap_pc", last_rpc, 32'h1000);
    csr_read(12'h341, v); chk("trap_mepc", v, 32'h100);
    chk("trap_done_rv", 32'(last_rv), 32'h0);
    csr_read(12'h342, v); chk("trap_mcause", v, 32'h8000_0007);
    csr_read(12'h300, v); chk("trap_mstatus", v, 32'h0000_1880);

    // External beats timer; simultaneous MRET dropped
    do_reset();
    if (VEC) csr_op(3'b001, 12'h305, 5'd1, 32'h1001);
    csr_op(3'b001, 12'h300, 5'd1, 32'h8);
    csr_op(3'b001, 12'h304, 5'd1, 32'h880);
    ext_irq = 1; timer_irq = 1; wb_commit = 1; wb_mret = 1; wb_next_pc = 32'h300;
    tick();
    idle_inputs();
    tick();
    chk("ext_rv", 32'(last_rv), 32'h1);
    chk("ext_pc", last_rpc, VEC ? 32'h0000_102C : RST_MTVEC);
    csr_read(12'h342, v); chk("ext_mcause", v, 32'h8000_000B);
    csr_read(12'h341, v); chk("ext_mepc", v, 32'h300);

    // MRET
    do_reset();
    csr_op(3'b001, 12'h341, 5'd1, 32'h200);
    csr_op(3'b001, 12'h300, 5'd1, 32'h80);
    wb_mret = 1;
    tick();
    chk("mret_latency_rv", 32'(last_rv), 32'h0);
    wb_mret = 0;
    tick();
    chk("mret_rv", 32'(last_rv), 32'h1);
    chk("mret_pc", last_rpc, 32'h200);
    csr_read(12'h300, v); chk("mret_mstatus", v, 32'h0000_1888);

    // Reset asserted while in TRAP
    do_reset();
    csr_op(3'b001, 12'h300, 5'd1, 32'h8);
    csr_op(3'b001, 12'h304, 5'd1, 32'h80);
    csr_op(3'b001, 12'h305, 5'd1, 32'h2000);
    timer_irq = 1; wb_commit = 1; wb_next_pc = 32'h104;
    tick();
    idle_inputs();
    rst = 0;
    #1;
    chk("abort_rv", 32'(redirect_valid), 32'h0);
    chk("abort_pc", redirect_pc, 32'h0);
    m_reset();
    @(posedge clk); @(negedge clk);
    rst = 1;
    csr_read(12'h341, v); chk("abort_mepc", v, 32'h0);
    csr_read(12'h342, v); chk("abort_mcause", v, 32'h0);
    csr_read(12'h305, v); chk("abort_mtvec", v, RST_MTVEC & TV_MASK);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      wb_csr_valid = 1'($urandom_range(0, 1));
      wb_funct3    = f3_pool[$urandom_range(0, 6)];
      wb_csr_addr  = adr_pool[$urandom_range(0, 7)];
      wb_rs1_idx   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      wb_rs1_data  = $urandom;
      wb_commit    = 1'($urandom_range(0, 1));
      wb_next_pc   = $urandom;
      wb_mret      = ($urandom_range(0, 7) == 0);
      ext_irq      = ($urandom_range(0, 3) == 0);
      timer_irq    = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
